// File: rtl/fp_align.sv
// Pre-add alignment stage for the FP add/sub datapath: exponent compare/swap, then a sticky-aware right shift.
// Optional sticky collection is enabled by defining FP_ALIGN_STICKY_EN; otherwise the shift simply truncates.
module fp_align #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               a_sign,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [SIG_W-1:0]   a_sig,
  input  logic               b_sign,
  input  logic [EXP_W-1:0]   b_exp,
  input  logic [SIG_W-1:0]   b_sig,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SIG_W+2:0]   out_sig_big,
  output logic [SIG_W+2:0]   out_sig_small,
  output logic               out_cin,
  output logic               out_eff_sub,
  output logic               out_swap
);

  localparam int OW = SIG_W + 3;

  // Handshake: a transfer happens on valid & ready at either boundary. Each stage
  // advances when it is empty or when the stage after it is advancing, so a full
  // pipe still moves one op per cycle and no op is dropped or duplicated.
  logic w_s1_en;
  logic w_s2_en;

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [EXP_W-1:0]   r_s1_exp;
  logic [SIG_W-1:0]   r_s1_big_sig;
  logic [SIG_W-1:0]   r_s1_small_sig;
  logic [EXP_W-1:0]   r_s1_diff;
  logic               r_s1_eff_sub;
  logic               r_s1_swap;

  logic               w_swap;
  logic [EXP_W-1:0]   w_big_exp;
  logic [EXP_W-1:0]   w_small_exp;
  logic [SIG_W-1:0]   w_big_sig;
  logic [SIG_W-1:0]   w_small_sig;
  logic               w_sign;
  logic               w_eff_sub;

  logic [OW-1:0]      w_ext;
  logic [OW-1:0]      w_sh_raw;
  logic [OW-1:0]      w_lost;
  logic [OW-1:0]      w_sh;

  assign w_s2_en  = !out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  // Stage 1: equal magnitudes keep a as big, so swap stays 0 on a full tie.
  always_comb begin
    w_swap      = (b_exp > a_exp) || ((b_exp == a_exp) && (b_sig > a_sig));
    w_big_exp   = w_swap ? b_exp : a_exp;
    w_small_exp = w_swap ? a_exp : b_exp;
    w_big_sig   = w_swap ? b_sig : a_sig;
    w_small_sig = w_swap ? a_sig : b_sig;
    w_sign      = w_swap ? (b_sign ^ sub) : a_sign;
    w_eff_sub   = a_sign ^ b_sign ^ sub;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_sign      <= 1'b0;
      r_s1_exp       <= '0;
      r_s1_big_sig   <= '0;
      r_s1_small_sig <= '0;
      r_s1_diff      <= '0;
      r_s1_eff_sub   <= 1'b0;
      r_s1_swap      <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign      <= w_sign;
        r_s1_exp       <= w_big_exp;
        r_s1_big_sig   <= w_big_sig;
        r_s1_small_sig <= w_small_sig;
        r_s1_diff      <= w_big_exp - w_small_exp;
        r_s1_eff_sub   <= w_eff_sub;
        r_s1_swap      <= w_swap;
      end
    end
  end

  // Stage 2: w_lost holds exactly the bits that fall off the bottom of the shift;
  // once diff reaches OW the whole extended significand is lost.
  always_comb begin
    w_ext    = {r_s1_small_sig, 3'b000};
    w_sh_raw = (int'(r_s1_diff) >= OW) ? '0 : (w_ext >> r_s1_diff);
    w_lost   = w_ext & ~({OW{1'b1}} << r_s1_diff);
`ifdef FP_ALIGN_STICKY_EN
    w_sh     = {w_sh_raw[OW-1:1], w_sh_raw[0] | (|w_lost)};
`else
    w_sh     = w_sh_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_sig_big   <= '0;
      out_sig_small <= '0;
      out_cin       <= 1'b0;
      out_eff_sub   <= 1'b0;
      out_swap      <= 1'b0;
    end else if (w_s2_en) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_sign      <= r_s1_sign;
        out_exp       <= r_s1_exp;
        out_sig_big   <= {r_s1_big_sig, 3'b000};
        out_sig_small <= r_s1_eff_sub ? ~w_sh : w_sh;
        out_cin       <= r_s1_eff_sub;
        out_eff_sub   <= r_s1_eff_sub;
        out_swap      <= r_s1_swap;
      end
    end
  end

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align: alignment vectors, shift boundaries, backpressure and reset flush.
module tb_fp_align;

`ifdef FP_ALIGN_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        a_sign = 1'b0, b_sign = 1'b0, sub = 1'b0;
  logic [7:0]  a_exp = '0, b_exp = '0;
  logic [23:0] a_sig = '0, b_sig = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [26:0] out_sig_big, out_sig_small;
  logic        out_cin, out_eff_sub, out_swap;

  int checks = 0;
  int errors = 0;

  fp_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_sig(a_sig),
    .b_sign(b_sign), .b_exp(b_exp), .b_sig(b_sig), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_sig_big(out_sig_big), .out_sig_small(out_sig_small),
    .out_cin(out_cin), .out_eff_sub(out_eff_sub), .out_swap(out_swap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic as, input logic [7:0] ae, input logic [23:0] asg,
                       input logic bs, input logic [7:0] be, input logic [23:0] bsg,
                       input logic sb);
    a_sign = as; a_exp = ae; a_sig = asg;
    b_sign = bs; b_exp = be; b_sig = bsg;
    sub = sb; in_valid = 1'b1;
  endtask

  // Offers one op, then returns at the cycle its result is expected (2 cycles after accept).
  task automatic one_op(input logic as, input logic [7:0] ae, input logic [23:0] asg,
                        input logic bs, input logic [7:0] be, input logic [23:0] bsg,
                        input logic sb);
    apply(as, ae, asg, bs, be, bsg, sb);
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++; if (out_sig_big !== 27'h0 || out_exp !== 8'h0) begin errors++;
      $display("FAIL reset_data big=%h exp=%0d want 0", out_sig_big, out_exp); end
  endtask

  task automatic test_add_basic();
    apply(1'b0, 8'd130, 24'hC00000, 1'b0, 8'd128, 24'h800000, 1'b0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early out_valid got=%0b want=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_2 out_valid got=%0b want=1", out_valid); end
    checks++; if (out_exp !== 8'd130) begin errors++; $display("FAIL add_exp got=%0d want=130", out_exp); end
    checks++; if (out_sig_big !== 27'h6000000) begin errors++; $display("FAIL add_big got=%h want=6000000", out_sig_big); end
    checks++; if (out_sig_small !== 27'h1000000) begin errors++; $display("FAIL add_small got=%h want=1000000", out_sig_small); end
    checks++; if (out_cin !== 1'b0 || out_swap !== 1'b0 || out_eff_sub !== 1'b0) begin errors++;
      $display("FAIL add_flags cin=%0b swap=%0b eff=%0b want 0 0 0", out_cin, out_swap, out_eff_sub); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_single_beat out_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_swap_eff_sub();
    one_op(1'b0, 8'd100, 24'h800000, 1'b1, 8'd101, 24'h800000, 1'b0);
    checks++; if (out_swap !== 1'b1 || out_exp !== 8'd101) begin errors++;
      $display("FAIL swap_sel swap=%0b exp=%0d want 1 101", out_swap, out_exp); end
    checks++; if (out_sign !== 1'b1 || out_eff_sub !== 1'b1 || out_cin !== 1'b1) begin errors++;
      $display("FAIL swap_flags sign=%0b eff=%0b cin=%0b want 1 1 1", out_sign, out_eff_sub, out_cin); end
    checks++; if (out_sig_big !== 27'h4000000 || out_sig_small !== 27'h5FFFFFF) begin errors++;
      $display("FAIL swap_sigs big=%h small=%h want 4000000 5FFFFFF", out_sig_big, out_sig_small); end
  endtask

  task automatic test_sub_diff0();
    one_op(1'b0, 8'd127, 24'h900000, 1'b0, 8'd127, 24'h800000, 1'b1);
    checks++; if (out_sig_big !== 27'h4800000) begin errors++; $display("FAIL sub0_big got=%h want=4800000", out_sig_big); end
    checks++; if (out_sig_small !== 27'h3FFFFFF) begin errors++; $display("FAIL sub0_small got=%h want=3FFFFFF", out_sig_small); end
    checks++; if (out_cin !== 1'b1 || out_eff_sub !== 1'b1 || out_swap !== 1'b0) begin errors++;
      $display("FAIL sub0_flags cin=%0b eff=%0b swap=%0b want 1 1 0", out_cin, out_eff_sub, out_swap); end
    // Full tie: a stays big, b sign flipped by sub does not matter for sign.
    one_op(1'b0, 8'd50, 24'hABCDEF, 1'b0, 8'd50, 24'hABCDEF, 1'b0);
    checks++; if (out_swap !== 1'b0 || out_sig_small !== 27'h55E6F78) begin errors++;
      $display("FAIL tie swap=%0b small=%h want 0 55E6F78", out_swap, out_sig_small); end
  endtask

  task automatic test_shift_boundaries();
    one_op(1'b0, 8'd200, 24'h800000, 1'b0, 8'd160, 24'h800001, 1'b0);
    checks++; if (out_sig_small !== {26'h0, STICKY}) begin errors++;
      $display("FAIL shift_40 got=%h want=%h", out_sig_small, {26'h0, STICKY}); end
    one_op(1'b0, 8'd100, 24'h800000, 1'b0, 8'd73, 24'h800000, 1'b0);
    checks++; if (out_sig_small !== {26'h0, STICKY}) begin errors++;
      $display("FAIL shift_27 got=%h want=%h", out_sig_small, {26'h0, STICKY}); end
    one_op(1'b0, 8'd100, 24'h800000, 1'b0, 8'd74, 24'h800000, 1'b0);
    checks++; if (out_sig_small !== 27'h0000001) begin errors++; $display("FAIL shift_26 got=%h want=0000001", out_sig_small); end
    one_op(1'b0, 8'd100, 24'h800000, 1'b0, 8'd75, 24'h800001, 1'b0);
    checks++; if (out_sig_small !== {25'h0, 1'b1, STICKY}) begin errors++;
      $display("FAIL shift_25 got=%h want=%h", out_sig_small, {25'h0, 1'b1, STICKY}); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exps[3];
    int idx;
    int n;
    int cyc;
    logic rdy;
    exps[0] = 8'd10; exps[1] = 8'd20; exps[2] = 8'd30;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, exps[idx], 24'h800000, 1'b0, exps[idx], 24'h800000, 1'b0);
      rdy = in_ready;
      step();
      if (rdy && idx < 2) idx++;
      else if (rdy) idx = 3;
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted got=%0d want=2", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
    repeat (2) step();
    checks++; if (out_valid !== 1'b1 || out_exp !== 8'd10 || out_sig_big !== 27'h4000000) begin errors++;
      $display("FAIL bp_stable valid=%0b exp=%0d big=%h want 1 10 4000000", out_valid, out_exp, out_sig_big); end
    out_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 20) begin
      if (idx < 3) apply(1'b0, exps[idx], 24'h800000, 1'b0, exps[idx], 24'h800000, 1'b0);
      else in_valid = 1'b0;
      rdy = in_ready && in_valid;
      if (out_valid) begin
        checks++; if (out_exp !== exps[n]) begin errors++; $display("FAIL bp_order[%0d] got=%0d want=%0d", n, out_exp, exps[n]); end
        n++;
      end
      step();
      if (rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_drain_count got=%0d want=3", n); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup out_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    apply(1'b0, 8'd40, 24'h800000, 1'b0, 8'd39, 24'h800000, 1'b0);
    step();
    apply(1'b0, 8'd41, 24'h800000, 1'b0, 8'd41, 24'h800000, 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_exp !== 8'd40 || out_sig_small !== 27'h2000000) begin errors++;
      $display("FAIL b2b_0 valid=%0b exp=%0d small=%h want 1 40 2000000", out_valid, out_exp, out_sig_small); end
    step();
    checks++; if (out_valid !== 1'b1 || out_exp !== 8'd41 || out_sig_small !== 27'h3FFFFFF) begin errors++;
      $display("FAIL b2b_1 valid=%0b exp=%0d small=%h want 1 41 3FFFFFF", out_valid, out_exp, out_sig_small); end
    step();
  endtask

  task automatic test_reset_flush();
    int stale;
    out_ready = 1'b1;
    apply(1'b0, 8'd60, 24'h800000, 1'b0, 8'd60, 24'h800000, 1'b0);
    step();
    apply(1'b0, 8'd61, 24'h800000, 1'b0, 8'd61, 24'h800000, 1'b0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL flush_state valid=%0b ready=%0b want 0 1", out_valid, in_ready); end
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale got=%0d want=0", stale); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_swap_eff_sub();
    test_sub_diff0();
    test_shift_boundaries();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
